// File: rtl/echo_unloader.sv
// echo_unloader: copies one completed echo record out of the recording-channel
// FIFO into the frame buffer RAM. Each record becomes a frame with this layout:
//   addr 0      timestamp low byte
//   addr 1      timestamp high bits, zero-extended
//   addr 2      len = min(sample_length, fifo_usdw)
//   addr 3+i    data word i, for i = 0..len-1
//   addr 3+len  XOR of all data words (only when UNLOADER_CHECKSUM_EN is defined)
// After the frame is written, frame_ready stays high until frame_ack.
//
// Optional feature: define the macro UNLOADER_CHECKSUM_EN to append the
// checksum word. This adds one cycle to the unload latency.
//
// Ports
//   clk, reset           clock; asynchronous active-low reset
//   echo_pulse_detected  a record is complete; sample_length, fifo_usdw and
//                        timestamp are captured on this pulse
//   fifo_rdreq / fifo_q  non-showahead FIFO read port (q valid 1 cycle later)
//   ram_we/addr/d        frame buffer write port
//   frame_ready/ack      frame handshake to the consumer
//   busy                 high whenever the unloader is not idle
//   len_err              sticky; set when sample_length exceeded fifo_usdw
module echo_unloader #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned TS_W   = 13,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              echo_pulse_detected,
  input  logic [DATA_W-1:0] sample_length,
  input  logic [DATA_W-1:0] fifo_usdw,
  input  logic [DATA_W-1:0] fifo_q,
  input  logic [TS_W-1:0]   timestamp,
  output logic              fifo_rdreq,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_d,
  output logic              frame_ready,
  input  logic              frame_ack,
  output logic              busy,
  output logic              len_err
);

  localparam int unsigned HDR_WORDS = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_HDR2,
    S_DRAIN,
    S_FLUSH,
    S_READY
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] ts_hi_q, ts_hi_d;
  logic [DATA_W-1:0] len_q, len_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic              rdreq_q, rdreq_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dreg_q, dreg_d;
  logic              dsel_q, dsel_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              len_err_q, len_err_d;

  logic [DATA_W-1:0] len_min_c;
  logic [DATA_W-1:0] data_word_c;

`ifdef UNLOADER_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
  logic              ext_q, ext_d;
`endif

  // Record length is clamped to what the FIFO actually holds
  assign len_min_c = (sample_length > fifo_usdw) ? fifo_usdw : sample_length;

  // FIFO word arriving this cycle (zero when no read was issued last cycle)
  assign data_word_c = dsel_q ? fifo_q : '0;

  // State and registered-output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      ts_hi_q   <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      rdreq_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      dreg_q    <= '0;
      dsel_q    <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ts_hi_q   <= ts_hi_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      rdreq_q   <= rdreq_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      dreg_q    <= dreg_d;
      dsel_q    <= dsel_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      len_err_q <= len_err_d;
    end
  end

`ifdef UNLOADER_CHECKSUM_EN
  // Running checksum and flush-extension flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csum_q <= '0;
      ext_q  <= 1'b0;
    end else begin
      csum_q <= csum_d;
      ext_q  <= ext_d;
    end
  end
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    ts_hi_d   = ts_hi_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    rdreq_d   = 1'b0;
    len_err_d = len_err_q;
    // A data write always follows a read by one cycle, landing at 3+index
    we_d      = rdreq_q;
    addr_d    = rdreq_q ? ADDR_W'(HDR_WORDS) + ADDR_W'(cnt_q) : '0;
    dreg_d    = '0;
    dsel_d    = rdreq_q;
`ifdef UNLOADER_CHECKSUM_EN
    csum_d    = csum_q ^ data_word_c;
    ext_d     = ext_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (echo_pulse_detected) begin
          state_d   = S_HDR0;
          ts_hi_d   = DATA_W'(timestamp >> DATA_W);
          len_d     = len_min_c;
          len_err_d = len_err_q | (sample_length > fifo_usdw);
          we_d      = 1'b1;
          addr_d    = ADDR_W'(0);
          dreg_d    = DATA_W'(timestamp);
`ifdef UNLOADER_CHECKSUM_EN
          csum_d    = '0;
          ext_d     = 1'b0;
`endif
        end
      end

      S_HDR0: begin
        state_d = S_HDR1;
        we_d    = 1'b1;
        addr_d  = ADDR_W'(1);
        dreg_d  = ts_hi_q;
      end

      S_HDR1: begin
        state_d = S_HDR2;
        we_d    = 1'b1;
        addr_d  = ADDR_W'(2);
        dreg_d  = len_q;
      end

      S_HDR2: begin
        cnt_d = '0;
        if (len_q != '0) begin
          state_d = S_DRAIN;
          rdreq_d = 1'b1;
        end else begin
          state_d = S_FLUSH;
        end
      end

      // cnt_q is the index of the read issued in this cycle
      S_DRAIN: begin
        cnt_d = cnt_q + DATA_W'(1);
        if (cnt_q == len_q - DATA_W'(1)) begin
          state_d = S_FLUSH;
        end else begin
          rdreq_d = 1'b1;
        end
      end

      // The last data word is written here; optionally one more cycle for the checksum
      S_FLUSH: begin
`ifdef UNLOADER_CHECKSUM_EN
        if (!ext_q) begin
          ext_d  = 1'b1;
          we_d   = 1'b1;
          addr_d = ADDR_W'(HDR_WORDS) + ADDR_W'(len_q);
          dreg_d = csum_q ^ data_word_c;
        end else begin
          ext_d   = 1'b0;
          state_d = S_READY;
        end
`else
        state_d = S_READY;
`endif
      end

      S_READY: begin
        if (frame_ack) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_READY);
    busy_d  = (state_d != S_IDLE);
  end

  assign fifo_rdreq  = rdreq_q;
  assign ram_we      = we_q;
  assign ram_addr    = addr_q;
  // FIFO data bypasses the output register so each word is written the cycle it arrives
  assign ram_d       = dsel_q ? fifo_q : dreg_q;
  assign frame_ready = ready_q;
  assign busy        = busy_q;
  assign len_err     = len_err_q;

endmodule

// File: tb/tb_echo_unloader.sv
// Scoreboard bench for echo_unloader: expected RAM writes are queued when a
// record is issued and popped by an independent write monitor.
module tb_echo_unloader;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned TS_W   = 13;
  localparam int unsigned ADDR_W = 9;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              echo_pulse_detected = 1'b0;
  logic [DATA_W-1:0] sample_length = '0;
  logic [DATA_W-1:0] fifo_usdw = '0;
  logic [DATA_W-1:0] fifo_q;
  logic [TS_W-1:0]   timestamp = '0;
  logic              fifo_rdreq;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_d;
  logic              frame_ready;
  logic              frame_ack = 1'b0;
  logic              busy;
  logic              len_err;

  wr_t               exp_q[$];
  logic [DATA_W-1:0] fifo_mem[$];
  logic [DATA_W-1:0] stim_q[$];
  int                n_vec = 0;
  int                n_err = 0;
  int                rd_cnt = 0;

  echo_unloader #(.DATA_W(DATA_W), .TS_W(TS_W), .ADDR_W(ADDR_W)) dut (
    .clk                 (clk),
    .reset               (reset),
    .echo_pulse_detected (echo_pulse_detected),
    .sample_length       (sample_length),
    .fifo_usdw           (fifo_usdw),
    .fifo_q              (fifo_q),
    .timestamp           (timestamp),
    .fifo_rdreq          (fifo_rdreq),
    .ram_we              (ram_we),
    .ram_addr            (ram_addr),
    .ram_d               (ram_d),
    .frame_ready         (frame_ready),
    .frame_ack           (frame_ack),
    .busy                (busy),
    .len_err             (len_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Non-showahead FIFO model
  always @(posedge clk or negedge reset) begin
    if (!reset) fifo_q <= '0;
    else if (fifo_rdreq) begin
      if (fifo_mem.size() > 0) fifo_q <= fifo_mem.pop_front();
      else fifo_q <= '0;
    end
  end

  // Monitor: every RAM write is checked against the scoreboard, every read for underflow
  always @(negedge clk) begin
    if (reset) begin
      if (fifo_rdreq) begin
        rd_cnt++;
        chk("fifo_not_empty_on_rdreq", 32'(fifo_mem.size() > 0), 32'd1);
      end
      if (ram_we) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_write: got addr=0x%0h data=0x%0h, expected no write", ram_addr, ram_d);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("ram_write{addr,data}", 32'({ram_addr, ram_d}), 32'(e));
        end
      end
    end
  end

  // Issue one record whose FIFO data is stim_q; check latency, reads, len_err, handshake
  task automatic run_record(input logic [DATA_W-1:0] sl, input logic [DATA_W-1:0] usdw,
                            input logic [TS_W-1:0] ts, input bit disturb, input bit exp_err);
    int                len;
    int                cyc;
    int                exp_lat;
    bit                seen;
    logic [DATA_W-1:0] x;
    len = (sl > usdw) ? int'(usdw) : int'(sl);
    foreach (stim_q[i]) fifo_mem.push_back(stim_q[i]);
    exp_q.push_back({ADDR_W'(0), DATA_W'(ts)});
    exp_q.push_back({ADDR_W'(1), DATA_W'(ts >> 8)});
    exp_q.push_back({ADDR_W'(2), DATA_W'(len)});
    x = '0;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back({ADDR_W'(3 + i), stim_q[i]});
      x = x ^ stim_q[i];
    end
    exp_lat = len + 5;
`ifdef UNLOADER_CHECKSUM_EN
    exp_q.push_back({ADDR_W'(3 + len), x});
    exp_lat = exp_lat + 1;
`endif
    rd_cnt = 0;
    @(posedge clk); #1;
    sample_length       = sl;
    fifo_usdw           = usdw;
    timestamp           = ts;
    echo_pulse_detected = 1'b1;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        echo_pulse_detected = 1'b0;
        sample_length       = 8'hEE;
      end
      if (disturb && cyc == 5) begin
        echo_pulse_detected = 1'b1;
        frame_ack           = 1'b1;
        timestamp           = 13'h1FFF;
        sample_length       = 8'hFF;
        fifo_usdw           = 8'hFF;
      end
      if (disturb && cyc == 6) begin
        echo_pulse_detected = 1'b0;
        frame_ack           = 1'b0;
      end
      if (frame_ready) seen = 1'b1;
    end
    chk("frame_ready_latency", seen ? 32'(cyc) : 32'hDEAD, 32'(exp_lat));
    chk("rdreq_cycles", 32'(rd_cnt), 32'(len));
    chk("frame_writes_done", 32'(exp_q.size()), 32'd0);
    chk("len_err", 32'(len_err), 32'(exp_err));
    @(posedge clk); #1;
    chk("frame_ready_held", 32'(frame_ready), 32'd1);
    frame_ack = 1'b1;
    @(posedge clk); #1;
    frame_ack = 1'b0;
    chk("ready_busy_after_ack", 32'({frame_ready, busy}), 32'd0);
    stim_q.delete();
    fifo_mem.delete();
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_strobes{rdreq,we,ready,busy,err}",
        32'({fifo_rdreq, ram_we, frame_ready, busy, len_err}), 32'd0);
    chk("reset_addr_data", 32'({ram_addr, ram_d}), 32'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Basic four-word record
    stim_q = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
    run_record(8'd4, 8'd4, 13'h1A5, 1'b0, 1'b0);

    // Empty record: header only
    run_record(8'd0, 8'd5, 13'h0777, 1'b0, 1'b0);

    // Three words with a distinctive checksum (07)
    stim_q = '{8'h01, 8'h02, 8'h04};
    run_record(8'd3, 8'd7, 13'h00C3, 1'b0, 1'b0);

    // Echo pulse, ack and input changes during DRAIN are all ignored
    stim_q = '{8'h5A, 8'hA5, 8'h3C, 8'hC3};
    run_record(8'd4, 8'd4, 13'h1234, 1'b1, 1'b0);

    // Reset while the read for word 2 is in flight
    stim_q = '{8'h31, 8'h32, 8'h33, 8'h34};
    foreach (stim_q[i]) fifo_mem.push_back(stim_q[i]);
    exp_q.push_back({ADDR_W'(0), 8'h56});
    exp_q.push_back({ADDR_W'(1), 8'h04});
    exp_q.push_back({ADDR_W'(2), 8'h04});
    exp_q.push_back({ADDR_W'(3), 8'h31});
    rd_cnt = 0;
    @(posedge clk); #1;
    sample_length       = 8'd4;
    fifo_usdw           = 8'd4;
    timestamp           = 13'h0456;
    echo_pulse_detected = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (c == 1) echo_pulse_detected = 1'b0;
    end
    chk("rdreq_before_reset", 32'(fifo_rdreq), 32'd1);
    reset = 1'b0;
    #1;
    chk("midreset_strobes{rdreq,we,ready,busy,err}",
        32'({fifo_rdreq, ram_we, frame_ready, busy, len_err}), 32'd0);
    chk("midreset_addr_data", 32'({ram_addr, ram_d}), 32'd0);
    chk("midreset_writes_done", 32'(exp_q.size()), 32'd0);
    chk("midreset_rdreq_cycles", 32'(rd_cnt), 32'd2);
    fifo_mem.delete();
    stim_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;

    // Recovery record after the abort
    stim_q = '{8'h77, 8'h88};
    run_record(8'd2, 8'd9, 13'h0042, 1'b0, 1'b0);

    // Over-claimed length: clamped to 16, len_err raised
    for (int i = 0; i < 16; i++) stim_q.push_back(8'(8'h80 + i));
    run_record(8'd20, 8'd16, 13'h1FFF, 1'b0, 1'b1);

    // len_err is sticky across records
    run_record(8'd0, 8'd0, 13'h0100, 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/echo_unloader.md
ECHO_UNLOADER -- requirements
Module: echo_unloader

Interface
REQ-001 SHALL have parameter DATA_W, default 8, FIFO/RAM data width.
REQ-002 SHALL have parameter TS_W, default 13, timestamp width (TS_W <= 2*DATA_W).
REQ-003 SHALL have parameter ADDR_W, default 9, buffer RAM address width.
REQ-004 SHALL have ports: clk  in  1  single clock, adc domain; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 echo_pulse_detected  in  1  one-cycle pulse: a record is complete in the recording channel FIFO.
REQ-007 sample_length  in  DATA_W  words the recording channel claims are stored; sampled on echo_pulse_detected.
REQ-008 fifo_usdw  in  DATA_W  words currently in FIFO; sampled on echo_pulse_detected.
REQ-009 fifo_q  in  DATA_W  FIFO read data, valid exactly 1 cycle after fifo_rdreq (non-showahead).
REQ-010 timestamp  in  TS_W  stop-pulse timestamp; sampled on echo_pulse_detected.
REQ-011 fifo_rdreq  out  1  FIFO read request.
REQ-012 ram_we  out  1  buffer RAM write enable.
REQ-013 ram_addr  out  ADDR_W  buffer RAM write address.
REQ-014 ram_d  out  DATA_W  buffer RAM write data.
REQ-015 frame_ready  out  1  frame complete in RAM, level until acknowledged.
REQ-016 frame_ack  in  1  one-cycle consumer acknowledge.
REQ-017 busy  out  1  high in any state except IDLE.
REQ-018 len_err  out  1  sticky: sample_length exceeded fifo_usdw on some record.

Function
REQ-019 FSM states SHALL be IDLE, HDR0, HDR1, HDR2, DRAIN, FLUSH, READY.
REQ-020 IDLE -> HDR0 on echo_pulse_detected; latch timestamp, len = min(sample_length, fifo_usdw); set len_err if sample_length > fifo_usdw.
REQ-021 HDR0 writes ts[7:0] at addr 0; HDR1 writes ts[TS_W-1:8] zero-extended at addr 1; HDR2 writes len at addr 2; one cycle each, ram_we high.
REQ-022 HDR2 -> DRAIN if len != 0, else -> FLUSH.
REQ-023 DRAIN SHALL assert fifo_rdreq for exactly len consecutive cycles, then -> FLUSH.
REQ-024 Each fifo_q word SHALL be written at addr 3+i (i = 0..len-1) one cycle after its fifo_rdreq; last write occurs in FLUSH.
REQ-025 FLUSH -> READY after one cycle; READY holds frame_ready = 1 until frame_ack, then -> IDLE.
REQ-026 echo_pulse_detected outside IDLE SHALL be ignored (FIFO retains data; no latch update).
REQ-027 frame_ack outside READY SHALL be ignored.
REQ-028 Address arithmetic SHALL be ADDR_W-bit; len <= 2^ADDR_W - 4 guaranteed by parameter choice, no wrap handling.
REQ-029 Latency: echo_pulse_detected to frame_ready = len + 5 cycles.
REQ-030 fifo_rdreq SHALL never exceed latched len per record (no FIFO underflow).

Reset
REQ-031 reset low SHALL asynchronously force IDLE; fifo_rdreq, ram_we, frame_ready, busy, len_err = 0; ram_addr, ram_d = 0; latches = 0.
REQ-032 reset mid-DRAIN SHALL abort immediately; residual FIFO content is cleared by the recording channel's own aclr.
REQ-033 len_err SHALL clear only by reset.

Configuration
REQ-034 Macro UNLOADER_CHECKSUM_EN defined: FLUSH extended one cycle writing XOR of all data words (0 if len = 0) at addr 3+len; latency len + 6.
REQ-035 Macro undefined: no checksum word, latency per REQ-029, no checksum register.

Verification
REQ-036 echo pulse, sample_length=4, fifo_usdw=4, ts=0x1A5, fifo_q=10,11,12,13 -> RAM[0..6]=A5,01,04,0A,0B,0C,0D; frame_ready at cycle 9; 4 rdreq cycles.
REQ-037 sample_length=0 -> RAM[0..2] written, no fifo_rdreq, frame_ready after 5 cycles.
REQ-038 sample_length=20, fifo_usdw=16 -> len_err=1, RAM[2]=16, exactly 16 rdreq cycles.
REQ-039 second echo pulse during DRAIN and frame_ack during DRAIN -> both ignored, frame contents unchanged.
REQ-040 reset low during DRAIN word 2 -> all outputs 0 same cycle, IDLE; next record unloads correctly.
REQ-041 with UNLOADER_CHECKSUM_EN, data 10,11,12,13 -> RAM[7]=0x00 wait—XOR=0x00? no: 0A^0B^0C^0D = 0x00; use data 01,02,04 -> RAM[6]=0x07, frame_ready at len+6.
